scanline_pos_gen: RTL and testbench
===================================

SCANLINE_POS_GEN -- requirements
Module: scanline_pos_gen

Interface
REQ-001 SHALL provide parameter LINE_CNT_WIDTH, default 11, width of the active-line counter.
REQ-002 SHALL provide VCLK_i  input  1  video clock; all logic on its rising edge.
REQ-003 SHALL provide nVRST_i  input  1  reset; one clock, asynchronous, active-low.
REQ-004 SHALL provide HSYNC_i, VSYNC_i, DE_i  input  1 each  video timing, active-high; frame start = VSYNC_i rising edge.
REQ-005 SHALL provide vdata_i  input  3*color_width_o (`VDATA_O_CO_SLICE)  RGB pixel data.
REQ-006 SHALL provide sl_en_i  input  1  scanline enable request.
REQ-007 SHALL provide sl_v_step_i  input  8  phase increment per output line, 1/256 of a source line (8'h40 = 4x vertical scale).
REQ-008 SHALL provide sl_v_offset_i  input  8  phase at first active line of a frame.
REQ-009 SHALL provide HSYNC_o, VSYNC_o, DE_o  output  1 each  timing delayed to align with sl_rel_pos_o.
REQ-010 SHALL provide vdata_o  output  3*color_width_o  pixel data delayed identically.
REQ-011 SHALL provide sl_en_o  output  1  qualified scanline enable for the downstream scanline stage.
REQ-012 SHALL provide sl_rel_pos_o  output  8  relative vertical position of current output line within its source line.
REQ-013 SHALL provide line_cnt_o  output  LINE_CNT_WIDTH  index of current active line in frame.

Function
REQ-014 SHALL delay HSYNC/VSYNC/DE/vdata by exactly 2 VCLK_i cycles, input to output.
REQ-015 SHALL implement states WAIT_VS (after reset), BLANK, ACTIVE.
REQ-016 SHALL move WAIT_VS->BLANK on first VSYNC_i rising edge; BLANK->ACTIVE on DE_i rising edge; ACTIVE->BLANK on DE_i falling edge.
REQ-017 SHALL, on every VSYNC_i rising edge (any state), load phase accumulator with sl_v_offset_i, clear line counter, and shadow sl_v_step_i; step changes take effect only at next frame start.
REQ-018 SHALL, on DE_i rising edge, latch sl_rel_pos from phase; value held constant for the whole line and aligned so sl_rel_pos_o is valid on the first cycle DE_o=1.
REQ-019 SHALL, on DE_i falling edge, add shadowed step to phase modulo 256 (wrap, no saturation) and increment line counter.
REQ-020 SHALL saturate line counter at all-ones; no wrap.
REQ-021 SHALL give VSYNC_i rising edge priority when coincident with a DE_i edge: frame-start load wins; no increment that cycle.
REQ-022 SHALL drive sl_en_o = sl_en_i registered AND (state != WAIT_VS), aligned with DE_o.
REQ-023 SHALL yield constant sl_rel_pos_o = sl_v_offset_i all frame when step = 0.
REQ-024 SHALL ignore DE_i edges in WAIT_VS (no latch, no increment).

Reset
REQ-025 SHALL, with nVRST_i low, force state WAIT_VS, phase 0, shadow step 0, line counter 0, all pipeline registers 0.
REQ-026 SHALL hold all outputs 0 during reset and until pipeline refills; reset mid-line discards the line and waits for next VSYNC_i.

Configuration
REQ-027 SHALL support macro SL_POS_CENTER_EN: when defined, latched sl_rel_pos = phase + (step>>1) mod 256 (line sampled at its centre); when undefined, sl_rel_pos = phase (line start); latency unchanged either way.

Verification
REQ-028 SHALL cover: reset, VSYNC rise, offset 0, step 8'h40, 8 lines -> sl_rel_pos_o 00,40,80,C0,00,40,80,C0; line_cnt_o 0..7.
REQ-029 SHALL cover: step 8'h55 changed to 8'h20 mid-frame -> current frame keeps 8'h55 increments; next frame uses 8'h20.
REQ-030 SHALL cover: VSYNC rise coincident with DE fall -> phase = offset, line_cnt_o = 0, no increment.
REQ-031 SHALL cover: DE lines before first VSYNC after reset -> sl_en_o = 0, sl_rel_pos_o = 0 despite sl_en_i = 1.
REQ-032 SHALL cover: SL_POS_CENTER_EN defined, offset 0, step 8'h40 -> 20,60,A0,E0; undefined -> 00,40,80,C0.
REQ-033 SHALL cover: nVRST_i pulsed low mid-line -> outputs 0 at once, recovery only after next VSYNC rise; data delay 2 cycles checked throughout.

Source files
------------

// File: rtl/scanline_pos_gen.sv
// Scanline position generator: delays video timing/data by two clocks and tags each
// output line with its relative vertical position inside the source line.
// Optional build macro SL_POS_CENTER_EN samples the position at the line centre.
module scanline_pos_gen #(
    parameter int LINE_CNT_WIDTH = 11,
    parameter int COLOR_WIDTH    = 8
) (
    input  logic                      VCLK_i,
    input  logic                      nVRST_i,
    input  logic                      HSYNC_i,
    input  logic                      VSYNC_i,
    input  logic                      DE_i,
    input  logic [3*COLOR_WIDTH-1:0]  vdata_i,
    input  logic                      sl_en_i,
    input  logic [7:0]                sl_v_step_i,
    input  logic [7:0]                sl_v_offset_i,
    output logic                      HSYNC_o,
    output logic                      VSYNC_o,
    output logic                      DE_o,
    output logic [3*COLOR_WIDTH-1:0]  vdata_o,
    output logic                      sl_en_o,
    output logic [7:0]                sl_rel_pos_o,
    output logic [LINE_CNT_WIDTH-1:0] line_cnt_o
);

    localparam int VW    = 3 * COLOR_WIDTH;
    localparam int DW    = VW + 4;
    localparam int DE_B  = VW;
    localparam int VS_B  = VW + 1;
    localparam int HS_B  = VW + 2;
    localparam int EN_B  = VW + 3;
    localparam int DEPTH = 2;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        BLANK   = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [DW-1:0] stage_in [DEPTH];
    logic [DW-1:0] pipe_reg [DEPTH];

    logic [7:0]                step_shadow_reg;
    logic [7:0]                phase_reg;
    logic [7:0]                rel_pos_reg;
    logic [7:0]                rel_pos_o_reg;
    logic [LINE_CNT_WIDTH-1:0] line_cnt_reg;
    logic [LINE_CNT_WIDTH-1:0] line_cnt_o_reg;
    logic [7:0]                rel_pos_calc;

    logic vs_rise;
    logic de_rise;
    logic de_fall;

    // Stage 0 doubles as the edge-detect history for VSYNC/DE.
    assign vs_rise = VSYNC_i & ~pipe_reg[0][VS_B];
    assign de_rise = DE_i    & ~pipe_reg[0][DE_B];
    assign de_fall = ~DE_i   &  pipe_reg[0][DE_B];

    // The scanline enable is qualified on its way into the last stage so it lines up with DE_o.
    always_comb begin
        stage_in[0]       = {sl_en_i, HSYNC_i, VSYNC_i, DE_i, vdata_i};
        stage_in[1]       = pipe_reg[0];
        stage_in[1][EN_B] = pipe_reg[0][EN_B] & (state_reg != WAIT_VS);
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pipe
            always_ff @(posedge VCLK_i or negedge nVRST_i) begin
                if (!nVRST_i) begin
                    pipe_reg[gi] <= '0;
                end else begin
                    pipe_reg[gi] <= stage_in[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge VCLK_i or negedge nVRST_i) begin
        if (!nVRST_i) begin
            state_reg <= WAIT_VS;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WAIT_VS: if (vs_rise) state_next = BLANK;
            BLANK:   if (de_rise) state_next = ACTIVE;
            ACTIVE:  if (de_fall) state_next = BLANK;
            default: state_next = WAIT_VS;
        endcase
    end

    // On a frame-start cycle the freshly loaded offset/step are what the line must see.
    always_comb begin
`ifdef SL_POS_CENTER_EN
        if (vs_rise) begin
            rel_pos_calc = sl_v_offset_i + {1'b0, sl_v_step_i[7:1]};
        end else begin
            rel_pos_calc = phase_reg + {1'b0, step_shadow_reg[7:1]};
        end
`else
        if (vs_rise) begin
            rel_pos_calc = sl_v_offset_i;
        end else begin
            rel_pos_calc = phase_reg;
        end
`endif
    end

    always_ff @(posedge VCLK_i or negedge nVRST_i) begin
        if (!nVRST_i) begin
            step_shadow_reg <= '0;
            phase_reg       <= '0;
            rel_pos_reg     <= '0;
            line_cnt_reg    <= '0;
        end else begin
            if (de_rise && state_reg != WAIT_VS) begin
                rel_pos_reg <= rel_pos_calc;
            end
            if (vs_rise) begin
                phase_reg       <= sl_v_offset_i;
                step_shadow_reg <= sl_v_step_i;
                line_cnt_reg    <= '0;
            end else if (de_fall && state_reg == ACTIVE) begin
                phase_reg <= phase_reg + step_shadow_reg;
                if (line_cnt_reg != {LINE_CNT_WIDTH{1'b1}}) begin
                    line_cnt_reg <= line_cnt_reg + 1'b1;
                end
            end
        end
    end

    // One extra register so position/count change together with the delayed DE.
    always_ff @(posedge VCLK_i or negedge nVRST_i) begin
        if (!nVRST_i) begin
            rel_pos_o_reg  <= '0;
            line_cnt_o_reg <= '0;
        end else begin
            rel_pos_o_reg  <= rel_pos_reg;
            line_cnt_o_reg <= line_cnt_reg;
        end
    end

    assign vdata_o      = pipe_reg[DEPTH-1][VW-1:0];
    assign DE_o         = pipe_reg[DEPTH-1][DE_B];
    assign VSYNC_o      = pipe_reg[DEPTH-1][VS_B];
    assign HSYNC_o      = pipe_reg[DEPTH-1][HS_B];
    assign sl_en_o      = pipe_reg[DEPTH-1][EN_B];
    assign sl_rel_pos_o = rel_pos_o_reg;
    assign line_cnt_o   = line_cnt_o_reg;

endmodule

// File: tb/tb_scanline_pos_gen.sv
// Directed bench for scanline_pos_gen; expectations follow SL_POS_CENTER_EN when defined.
module tb_scanline_pos_gen;

    localparam int LCW = 4;
    localparam int CW  = 8;
    localparam int VW  = 3 * CW;
    localparam int BW  = VW + 3;
`ifdef SL_POS_CENTER_EN
    localparam bit CENTER = 1'b1;
`else
    localparam bit CENTER = 1'b0;
`endif

    logic           VCLK_i = 1'b0;
    logic           nVRST_i;
    logic           HSYNC_i, VSYNC_i, DE_i, sl_en_i;
    logic [VW-1:0]  vdata_i;
    logic [7:0]     sl_v_step_i, sl_v_offset_i;
    logic           HSYNC_o, VSYNC_o, DE_o, sl_en_o;
    logic [VW-1:0]  vdata_o;
    logic [7:0]     sl_rel_pos_o;
    logic [LCW-1:0] line_cnt_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [BW-1:0] h1 = '0;
    logic [BW-1:0] h2 = '0;

    scanline_pos_gen #(.LINE_CNT_WIDTH(LCW), .COLOR_WIDTH(CW)) dut (
        .VCLK_i        (VCLK_i),
        .nVRST_i       (nVRST_i),
        .HSYNC_i       (HSYNC_i),
        .VSYNC_i       (VSYNC_i),
        .DE_i          (DE_i),
        .vdata_i       (vdata_i),
        .sl_en_i       (sl_en_i),
        .sl_v_step_i   (sl_v_step_i),
        .sl_v_offset_i (sl_v_offset_i),
        .HSYNC_o       (HSYNC_o),
        .VSYNC_o       (VSYNC_o),
        .DE_o          (DE_o),
        .vdata_o       (vdata_o),
        .sl_en_o       (sl_en_o),
        .sl_rel_pos_o  (sl_rel_pos_o),
        .line_cnt_o    (line_cnt_o)
    );

    always #5 VCLK_i = ~VCLK_i;

    function automatic logic [7:0] exp_pos(input logic [7:0] off, input logic [7:0] step, input int k);
        int v;
        v = int'(off) + k * int'(step) + (CENTER ? int'(step >> 1) : 0);
        return v[7:0];
    endfunction

    // Advance one clock; the timing/data outputs must equal what was sampled two edges earlier.
    task automatic tick();
        logic [BW-1:0] in_now;
        logic [BW-1:0] got;
        in_now = {HSYNC_i, VSYNC_i, DE_i, vdata_i};
        @(posedge VCLK_i);
        if (!nVRST_i) begin
            h1 = '0;
            h2 = '0;
        end else begin
            h2 = h1;
            h1 = in_now;
        end
        #1;
        got = {HSYNC_o, VSYNC_o, DE_o, vdata_o};
        n_cmp++;
        if (got !== h2) begin
            n_err++;
            $display("FAIL data_delay t=%0t: got %h want %h", $time, got, h2);
        end
    endtask

    task automatic frame_start(input logic [7:0] off, input logic [7:0] step);
        sl_v_offset_i = off;
        sl_v_step_i   = step;
        VSYNC_i = 1'b1; tick(); tick();
        VSYNC_i = 1'b0; tick(); tick();
        $display("frame start offset=%h step=%h", off, step);
    endtask

    task automatic run_line(input logic [7:0] ep, input logic [LCW-1:0] ec, input logic een, input string tag);
        DE_i = 1'b1; vdata_i = VW'($urandom); tick();
        vdata_i = VW'($urandom); tick();
        n_cmp += 3;
        if (sl_rel_pos_o !== ep) begin
            n_err++; $display("FAIL %s rel_pos_first: got %h want %h", tag, sl_rel_pos_o, ep);
        end
        if (line_cnt_o !== ec) begin
            n_err++; $display("FAIL %s line_cnt_first: got %0d want %0d", tag, line_cnt_o, ec);
        end
        if (sl_en_o !== een) begin
            n_err++; $display("FAIL %s sl_en: got %b want %b", tag, sl_en_o, een);
        end
        vdata_i = VW'($urandom); tick();
        vdata_i = VW'($urandom); tick();
        DE_i = 1'b0; vdata_i = '0; tick();
        n_cmp += 2;
        if (sl_rel_pos_o !== ep) begin
            n_err++; $display("FAIL %s rel_pos_last: got %h want %h", tag, sl_rel_pos_o, ep);
        end
        if (line_cnt_o !== ec) begin
            n_err++; $display("FAIL %s line_cnt_last: got %0d want %0d", tag, line_cnt_o, ec);
        end
        HSYNC_i = 1'b1; tick(); tick();
        HSYNC_i = 1'b0; tick();
        $display("line %s: pos=%h cnt=%0d en=%b", tag, sl_rel_pos_o, line_cnt_o, sl_en_o);
    endtask

    task automatic check_all_zero(input string tag);
        logic [BW+LCW+8:0] got;
        got = {HSYNC_o, VSYNC_o, DE_o, vdata_o, sl_en_o, sl_rel_pos_o, line_cnt_o};
        n_cmp++;
        if (got !== '0) begin
            n_err++; $display("FAIL %s outputs_zero: got %h want 0", tag, got);
        end
        $display("%s: outputs=%h", tag, got);
    endtask

    task automatic test_reset();
        tick(); tick();
        check_all_zero("reset_held");
        #1 nVRST_i = 1'b1;
        tick();
        check_all_zero("reset_released");
    endtask

    task automatic test_pre_vsync();
        sl_en_i = 1'b1;
        run_line(8'h00, '0, 1'b0, "pre_vs0");
        run_line(8'h00, '0, 1'b0, "pre_vs1");
    endtask

    task automatic test_basic();
        logic [7:0] tbl [8];
        if (CENTER) tbl = '{8'h20, 8'h60, 8'hA0, 8'hE0, 8'h20, 8'h60, 8'hA0, 8'hE0};
        else        tbl = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00, 8'h40, 8'h80, 8'hC0};
        frame_start(8'h00, 8'h40);
        for (int k = 0; k < 8; k++) run_line(tbl[k], LCW'(k), 1'b1, $sformatf("basic%0d", k));
    endtask

    task automatic test_step_change();
        frame_start(8'h10, 8'h55);
        for (int k = 0; k < 2; k++) run_line(exp_pos(8'h10, 8'h55, k), LCW'(k), 1'b1, $sformatf("stepA%0d", k));
        sl_v_step_i = 8'h20;
        for (int k = 2; k < 4; k++) run_line(exp_pos(8'h10, 8'h55, k), LCW'(k), 1'b1, $sformatf("stepA%0d", k));
        frame_start(8'h10, 8'h20);
        for (int k = 0; k < 3; k++) run_line(exp_pos(8'h10, 8'h20, k), LCW'(k), 1'b1, $sformatf("stepB%0d", k));
    endtask

    task automatic test_vs_de_coincident();
        logic [7:0] ep;
        frame_start(8'h33, 8'h40);
        for (int k = 0; k < 3; k++) run_line(exp_pos(8'h33, 8'h40, k), LCW'(k), 1'b1, $sformatf("coin%0d", k));
        ep = exp_pos(8'h33, 8'h40, 3);
        DE_i = 1'b1; vdata_i = VW'($urandom); tick();
        vdata_i = VW'($urandom); tick();
        n_cmp += 2;
        if (sl_rel_pos_o !== ep) begin
            n_err++; $display("FAIL coin3 rel_pos: got %h want %h", sl_rel_pos_o, ep);
        end
        if (line_cnt_o !== LCW'(3)) begin
            n_err++; $display("FAIL coin3 line_cnt: got %0d want 3", line_cnt_o);
        end
        tick(); tick();
        DE_i = 1'b0; VSYNC_i = 1'b1; vdata_i = '0; tick();
        tick();
        n_cmp++;
        if (line_cnt_o !== '0) begin
            n_err++; $display("FAIL coin_vs line_cnt_cleared: got %0d want 0", line_cnt_o);
        end
        VSYNC_i = 1'b0; tick(); tick();
        $display("coincident VSYNC/DE fall: cnt=%0d", line_cnt_o);
        run_line(exp_pos(8'h33, 8'h40, 0), '0, 1'b1, "coin_after0");
        run_line(exp_pos(8'h33, 8'h40, 1), LCW'(1), 1'b1, "coin_after1");
    endtask

    task automatic test_step_zero_saturate();
        frame_start(8'hA5, 8'h00);
        for (int k = 0; k < 18; k++)
            run_line(8'hA5, (k > 15) ? LCW'(15) : LCW'(k), 1'b1, $sformatf("sat%0d", k));
    endtask

    task automatic test_reset_midline();
        frame_start(8'h00, 8'h40);
        run_line(exp_pos(8'h00, 8'h40, 0), '0, 1'b1, "mid0");
        DE_i = 1'b1; vdata_i = VW'($urandom); tick();
        vdata_i = VW'($urandom); tick(); tick();
        #2 nVRST_i = 1'b0;
        h1 = '0; h2 = '0;
        #1;
        check_all_zero("reset_midline");
        tick();
        check_all_zero("reset_midline_edge");
        nVRST_i = 1'b1;
        vdata_i = VW'($urandom); tick(); tick();
        DE_i = 1'b0; vdata_i = '0; tick(); tick(); tick();
        run_line(8'h00, '0, 1'b0, "post_rst_novs");
        frame_start(8'h80, 8'h40);
        run_line(exp_pos(8'h80, 8'h40, 0), '0, 1'b1, "post_rst0");
        run_line(exp_pos(8'h80, 8'h40, 1), LCW'(1), 1'b1, "post_rst1");
    endtask

    initial begin
        nVRST_i = 1'b0;
        HSYNC_i = 1'b0; VSYNC_i = 1'b0; DE_i = 1'b0; sl_en_i = 1'b0;
        vdata_i = '0; sl_v_step_i = '0; sl_v_offset_i = '0;
        test_reset();
        test_pre_vsync();
        test_basic();
        test_step_change();
        test_vs_de_coincident();
        test_step_zero_saturate();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
